dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer in front of data_memory; shares the single byte-addressed data memory between port 0 (CPU load/store unit) and port 1 (DMA/debug).
- Accepts one transaction at a time, checks alignment, size and range, and drives the memory's load/store/size/signext/addr/din controls.
- Returns exactly one response per accepted transaction, after the memory's one-cycle registered read.

Parameters:
MEM_BYTES, 4096, memory depth in bytes; any byte of the access at address >= MEM_BYTES is a range error.

Ports:
clk  in  1  clock, all state on rising edge
arst_n  in  1  asynchronous reset, active-low
p0_req / p1_req  in  1  request; held with its fields until the port's gnt is seen
p0_we / p1_we  in  1  1 = store, 0 = load
p0_size / p1_size  in  2  00 byte, 01 half, 10 word, 11 illegal
p0_signext / p1_signext  in  1  sign-extend load data
p0_addr / p1_addr  in  32  byte address
p0_wdata / p1_wdata  in  32  store data, little-endian
p0_gnt / p1_gnt  out  1  one-cycle pulse: request accepted
p0_rvalid / p1_rvalid  out  1  one-cycle pulse: response valid
p0_rdata / p1_rdata  out  32  load data; 0 for stores and errors
p0_err / p1_err  out  1  qualifies rvalid: misaligned, illegal size or out of range
mem_load  out  1  to memory load
mem_store  out  1  to memory store
mem_size  out  2  to memory size
mem_signext  out  1  to memory signext
mem_addr  out  32  to memory addr
mem_din  out  32  to memory din
mem_dout  in  32  from memory dout; valid the cycle after mem_load

Behaviour:
- Reset (arst_n=0, asynchronous):
  - All outputs 0.
  - FSM goes to IDLE; round-robin pointer set to favour p0.
  - Applies mid-transaction: the in-flight transaction is dropped and produces no response.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
- IDLE, cycle N:
  - If any req is high, pick a winner and capture its fields at the end of cycle N; go to ACCESS.
  - With no req, stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - When both request, the port not granted most recently wins; the pointer updates on every grant.
- ACCESS, cycle N+1:
  - Winner's gnt = 1.
  - mem_size, mem_signext, mem_addr and mem_din = captured values.
  - If legal: mem_load = ~we, mem_store = we.
  - If err: both mem_load and mem_store are 0.
- RESP, cycle N+2:
  - Winner's rvalid = 1.
  - Load: rdata = mem_dout. Store or error: rdata = 0.
  - err = captured error flag.
- Error, evaluated on the captured fields:
  - size = 11.
  - size = 01 with addr[0] = 1.
  - size = 10 with addr[1:0] != 00.
  - addr + bytes - 1 >= MEM_BYTES.
- Outside ACCESS:
  - mem_load and mem_store are 0.
  - mem_size, mem_signext, mem_addr and mem_din hold their last value.
- Outside their pulse cycle, gnt, rvalid and err are 0 and rdata is 0.
- Request handling:
  - A req still high when the FSM returns to IDLE is a new request.
  - A req that rises during ACCESS or RESP waits for IDLE.
  - No request is lost or reordered; the loser of a simultaneous request is served next.
- Throughput: one transaction per 3 cycles, at most one outstanding.
- Fields changing while req is high before gnt: the value sampled in the IDLE capture cycle is used.

Test Plan:
- Reset, then p0 word store addr 0x10 data 0xDEADBEEF -> p0_gnt at N+1 with mem_store=1, mem_size=10, mem_addr=0x10; p0_rvalid at N+2, rdata 0, err 0.
- p0 byte load addr 0x13, signext=1, after the above -> mem_load at N+1; p0_rdata = 0xFFFFFFDE at N+2. Same with signext=0 -> 0x000000DE.
- p0 and p1 request in the same cycle, both held continuously -> grants alternate p0, p1, p0 …; each gnt is 3 cycles apart; no port is granted twice in a row.
- p1 half load addr 0x21; p1 word store addr 0x22; p0 size=11; p0 word load addr 0xFFE -> each gives rvalid with err=1 and rdata 0; mem_load/mem_store never asserted.
- arst_n pulsed low during ACCESS of a p1 store -> all outputs 0 immediately; no p1_rvalid; the next p0/p1 simultaneous request is granted to p0.
- p1 req rises during p0's RESP cycle -> p1 captured in the following IDLE cycle; p1_gnt one cycle later.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the shared byte-addressed data memory.
// One transaction at a time: IDLE captures a winner, ACCESS drives memory, RESP answers.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_signext,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_signext,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_load,
  output logic        mem_store,
  output logic [1:0]  mem_size,
  output logic        mem_signext,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

  state_e      state_q;
  logic        prio_q;
  logic        sel_q;
  logic        we_q;
  logic        xerr_q;
  logic        ld_q;
  logic [1:0]  gnt_q;
  logic [1:0]  rvalid_q;
  logic [1:0]  err_q;
  logic        mem_load_q;
  logic        mem_store_q;
  logic [1:0]  mem_size_q;
  logic        mem_sx_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_din_q;

  logic        any_req;
  logic        win;
  logic        c_we;
  logic [1:0]  c_size;
  logic        c_sx;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [2:0]  c_nbytes;
  logic [32:0] c_last;
  logic        c_err;

  // On a tie the pointer picks the port not granted most recently.
  always_comb begin
    any_req = p0_req | p1_req;
    win     = (p0_req & p1_req) ? prio_q : p1_req;
    c_we    = win ? p1_we      : p0_we;
    c_size  = win ? p1_size    : p0_size;
    c_sx    = win ? p1_signext : p0_signext;
    c_addr  = win ? p1_addr    : p0_addr;
    c_wdata = win ? p1_wdata   : p0_wdata;
    unique case (c_size)
      2'b00:   c_nbytes = 3'd1;
      2'b01:   c_nbytes = 3'd2;
      default: c_nbytes = 3'd4;
    endcase
    c_last = {1'b0, c_addr} + {30'd0, c_nbytes} - 33'd1;
    c_err  = (c_size == 2'b11)
           | ((c_size == 2'b01) & c_addr[0])
           | ((c_size == 2'b10) & (|c_addr[1:0]))
           | (c_last >= LIMIT);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      xerr_q      <= 1'b0;
      ld_q        <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      mem_load_q  <= 1'b0;
      mem_store_q <= 1'b0;
      mem_size_q  <= '0;
      mem_sx_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      mem_load_q  <= 1'b0;
      mem_store_q <= 1'b0;
      ld_q        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= ACCESS;
            prio_q      <= ~win;
            sel_q       <= win;
            we_q        <= c_we;
            xerr_q      <= c_err;
            gnt_q[win]  <= 1'b1;
            mem_load_q  <= ~c_err & ~c_we;
            mem_store_q <= ~c_err & c_we;
            mem_size_q  <= c_size;
            mem_sx_q    <= c_sx;
            mem_addr_q  <= c_addr;
            mem_din_q   <= c_wdata;
          end
        end
        ACCESS: begin
          state_q         <= RESP;
          rvalid_q[sel_q] <= 1'b1;
          err_q[sel_q]    <= xerr_q;
          ld_q            <= ~we_q & ~xerr_q;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory read data is already registered by the memory; only gate it here.
  assign p0_rdata = (rvalid_q[0] & ld_q) ? mem_dout : 32'd0;
  assign p1_rdata = (rvalid_q[1] & ld_q) ? mem_dout : 32'd0;

  assign p0_gnt      = gnt_q[0];
  assign p1_gnt      = gnt_q[1];
  assign p0_rvalid   = rvalid_q[0];
  assign p1_rvalid   = rvalid_q[1];
  assign p0_err      = err_q[0];
  assign p1_err      = err_q[1];
  assign mem_load    = mem_load_q;
  assign mem_store   = mem_store_q;
  assign mem_size    = mem_size_q;
  assign mem_signext = mem_sx_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array data memory model.
// Stimulus pushes expected grants/responses; a negedge monitor pops and compares.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n;
  logic [1:0] req, we, sx;
  logic [1:0][1:0] size;
  logic [1:0][31:0] addr, wdata;

  logic p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic mem_load, mem_store, mem_signext;
  logic [1:0] mem_size;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout = 32'd0;

  dmem_arbiter #(.MEM_BYTES(4096)) dut (
    .clk(clk), .arst_n(arst_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_size(size[0]),
    .p0_signext(sx[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(req[1]), .p1_we(we[1]), .p1_size(size[1]),
    .p1_signext(sx[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_load(mem_load), .mem_store(mem_store),
    .mem_size(mem_size), .mem_signext(mem_signext),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  logic [7:0] mem [0:4095];

  function automatic logic [31:0] rd(input logic [31:0] a,
                                     input logic [1:0] sz,
                                     input logic s);
    logic [11:0] i;
    logic [15:0] h;
    i = a[11:0];
    h = {mem[i+12'd1], mem[i]};
    case (sz)
      2'b00:   return s ? {{24{mem[i][7]}}, mem[i]} : {24'd0, mem[i]};
      2'b01:   return s ? {{16{h[15]}}, h} : {16'd0, h};
      default: return {mem[i+12'd3], mem[i+12'd2], h};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_store) begin
      mem[mem_addr[11:0]] <= mem_din[7:0];
      if (mem_size != 2'b00)
        mem[mem_addr[11:0]+12'd1] <= mem_din[15:8];
      if (mem_size == 2'b10) begin
        mem[mem_addr[11:0]+12'd2] <= mem_din[23:16];
        mem[mem_addr[11:0]+12'd3] <= mem_din[31:24];
      end
    end
    if (mem_load)
      mem_dout <= rd(mem_addr, mem_size, mem_signext);
  end

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] d;
  } gexp_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        e;
  } rexp_t;

  gexp_t gq0[$], gq1[$];
  rexp_t rq0[$], rq1[$];
  int ordq[$];
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  bit alt_mode = 1'b0;
  int last_gnt = -1;
  gexp_t mg;
  rexp_t mr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s", nm);
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      if (p0_gnt) begin
        if (gq0.size() == 0) bad("p0 unexpected gnt");
        else begin
          mg = gq0.pop_front();
          chk("p0 gnt mem ctl",
              72'({mem_load, mem_store, mem_size, mem_signext, mem_addr, mem_din}),
              72'(mg));
        end
      end
      if (p1_gnt) begin
        if (gq1.size() == 0) bad("p1 unexpected gnt");
        else begin
          mg = gq1.pop_front();
          chk("p1 gnt mem ctl",
              72'({mem_load, mem_store, mem_size, mem_signext, mem_addr, mem_din}),
              72'(mg));
        end
      end
      if (p0_gnt | p1_gnt) begin
        if (ordq.size() != 0)
          chk("gnt order", 72'(p1_gnt), 72'(ordq.pop_front()));
        if (alt_mode && last_gnt >= 0)
          chk("gnt spacing", 72'(cyc - last_gnt), 72'd3);
        last_gnt = cyc;
      end
      if ((mem_load | mem_store) && !(p0_gnt | p1_gnt))
        bad("mem strobe outside grant cycle");
      if (p0_rvalid) begin
        if (rq0.size() == 0) bad("p0 unexpected rvalid");
        else begin
          mr = rq0.pop_front();
          chk("p0 rsp", 72'({p0_rdata, p0_err}), 72'(mr));
        end
      end else begin
        chk("p0 idle rsp", 72'({p0_rdata, p0_err}), 72'd0);
      end
      if (p1_rvalid) begin
        if (rq1.size() == 0) bad("p1 unexpected rvalid");
        else begin
          mr = rq1.pop_front();
          chk("p1 rsp", 72'({p1_rdata, p1_err}), 72'(mr));
        end
      end else begin
        chk("p1 idle rsp", 72'({p1_rdata, p1_err}), 72'd0);
      end
    end
  end

  task automatic issue(input int p, input bit w, input logic [1:0] sz,
                       input bit s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] erd,
                       input bit ee, input bit push_rsp = 1'b1,
                       input bit now = 1'b0);
    gexp_t ge;
    rexp_t re;
    bit got;
    ge.ld = ~ee & ~w;
    ge.st = ~ee & w;
    ge.sz = sz;
    ge.sx = s;
    ge.a  = a;
    ge.d  = d;
    re.rd = erd;
    re.e  = ee;
    if (p == 0) gq0.push_back(ge);
    else gq1.push_back(ge);
    if (push_rsp) begin
      if (p == 0) rq0.push_back(re);
      else rq1.push_back(re);
    end
    if (!now) begin
      @(posedge clk);
      #1;
    end
    we[p] = w;
    size[p] = sz;
    sx[p] = s;
    addr[p] = a;
    wdata[p] = d;
    req[p] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((p == 0) ? p0_gnt : p1_gnt) begin
        got = 1'b1;
        break;
      end
    end
    req[p] = 1'b0;
    if (!got) begin
      bad($sformatf("p%0d gnt timeout addr %h", p, a));
      if (p == 0) void'(gq0.pop_back());
      else void'(gq1.pop_back());
      if (push_rsp) begin
        if (p == 0) void'(rq0.pop_back());
        else void'(rq1.pop_back());
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " strobes"},
        72'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
             mem_load, mem_store, mem_size, mem_signext}), 72'd0);
    chk({nm, " mem bus"}, 72'({mem_addr, mem_din}), 72'd0);
    chk({nm, " rdata"}, 72'({p0_rdata, p1_rdata}), 72'd0);
  endtask

  int rise_cyc;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    arst_n = 1'b0;
    req = '0; we = '0; sx = '0; size = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    arst_n = 1'b1;

    issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    issue(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h000000DE, 0);
    issue(0, 0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
    issue(0, 0, 2'b10, 0, 32'hFFC, 32'h0, 32'h0, 0);
    issue(1, 0, 2'b01, 0, 32'h21, 32'h0, 32'h0, 1);

    repeat (4) @(posedge clk);
    #1;
    alt_mode = 1'b1;
    last_gnt = -1;
    for (int i = 0; i < 3; i++) begin
      ordq.push_back(0);
      ordq.push_back(1);
    end
    fork
      begin
        for (int i = 0; i < 3; i++)
          issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
      end
      begin
        for (int i = 0; i < 3; i++)
          issue(1, 1, 2'b10, 0, 32'h40 + 32'(4 * i),
                32'hA5A50000 + 32'(i), 32'h0, 0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    alt_mode = 1'b0;

    issue(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'hA5A50001, 0);
    issue(1, 1, 2'b10, 0, 32'h22, 32'h11223344, 32'h0, 1);
    issue(0, 0, 2'b11, 0, 32'h30, 32'h0, 32'h0, 1);
    issue(0, 0, 2'b10, 0, 32'hFFE, 32'h0, 32'h0, 1);
    issue(0, 0, 2'b01, 0, 32'hFFF, 32'h0, 32'h0, 1);

    issue(1, 1, 2'b10, 0, 32'h50, 32'h12345678, 32'h0, 0, 1'b0);
    #2;
    arst_n = 1'b0;
    #1;
    chk_all_zero("mid-access reset");
    @(negedge clk);
    arst_n = 1'b1;
    ordq.push_back(0);
    ordq.push_back(1);
    fork
      issue(0, 0, 2'b10, 0, 32'h50, 32'h0, 32'h0, 0);
      issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    join

    fork
      issue(0, 0, 2'b00, 0, 32'h40, 32'h0, 32'h00000000, 0);
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (p0_rvalid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) bad("p0 rvalid timeout");
        rise_cyc = cyc;
        issue(1, 0, 2'b01, 0, 32'h42, 32'h0, 32'h0000A5A5, 0, 1'b1, 1'b1);
        chk("late p1 gnt latency", 72'(cyc - rise_cyc), 72'd2);
      end
    join

    repeat (8) @(posedge clk);
    #1;
    chk("queues drained",
        72'(gq0.size() + gq1.size() + rq0.size() + rq1.size() + ordq.size()),
        72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
